mux_scan_n_to_1: RTL and testbench
==================================

# mux_scan_n_to_1

Parametrised, registered N-to-1 multiplexer with two modes: manual channel selection and automatic round-robin scanning with a programmable dwell time. It extends the combinational 8-to-1 mux family with configurable channel count and registered outputs. It also reports which channel is being presented and pulses sample/sweep markers. It sits between a bank of parallel data sources and a single downstream consumer, such as a display driver or serial framer.

## Interface
- N_BITS, 8, width of each data channel
- N_CHANNELS, 8, number of input channels (2..256; power of two not required)
- SEL_WIDTH, 3, selector/channel index width; must equal ceil(log2(N_CHANNELS))
- DWELL, 4, cycles each channel is presented in scan mode (>= 1)
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- Enable  in  1  1 = operate; 0 = freeze all state and outputs
- Mode  in  1  0 = manual (Selector), 1 = scan
- Selector  in  SEL_WIDTH  channel index used in manual mode
- Data_In  in  N_CHANNELS*N_BITS  packed channels; channel k at bits [k*N_BITS +: N_BITS]
- Mux_Output  out  N_BITS  registered selected data
- Channel_Out  out  SEL_WIDTH  index of the channel currently on Mux_Output
- Sample_Valid  out  1  one-cycle pulse; Mux_Output loaded at this edge
- Sweep_Done  out  1  one-cycle pulse coincident with the load of channel N_CHANNELS-1 in scan mode

## Operation
- State register with three states: IDLE, MANUAL, SCAN. The state is updated every edge as follows:
  - Enable=0 → IDLE.
  - Enable=1, Mode=0 → MANUAL.
  - Enable=1, Mode=1 → SCAN.
- Internal registers: ptr (SEL_WIDTH bits) and dwell counter (range 0..DWELL-1).
- IDLE / Enable=0:
  - Mux_Output, Channel_Out, ptr and dwell hold their values.
  - Sample_Valid and Sweep_Done are 0.
- MANUAL, Selector < N_CHANNELS, on each edge:
  - Mux_Output <= channel[Selector]; Channel_Out <= Selector; Sample_Valid <= 1.
  - ptr <= 0; dwell <= 0.
- MANUAL, Selector >= N_CHANNELS (out of range):
  - Mux_Output and Channel_Out hold; Sample_Valid <= 0.
  - ptr and dwell are still cleared.
- SCAN, each edge:
  - If dwell == 0: Mux_Output <= channel[ptr]; Channel_Out <= ptr; Sample_Valid <= 1; Sweep_Done <= (ptr == N_CHANNELS-1).
  - Otherwise Sample_Valid and Sweep_Done are 0.
  - If dwell == DWELL-1: dwell <= 0 and ptr advances, wrapping N_CHANNELS-1 → 0. Otherwise dwell <= dwell+1.
- Sweep_Done is never asserted in MANUAL.
- Mode 0→1 always starts the scan at channel 0 with a full dwell, because ptr and dwell were cleared in MANUAL.
- Enable 1→0→1 while Mode=1 resumes at the frozen ptr/dwell; no dwell cycles are lost or repeated.
- DWELL=1: a new channel is loaded every enabled cycle, and Sample_Valid stays high continuously.
- Data_In changes during a dwell are not reflected on Mux_Output until the next load edge.

## Timing
- Asynchronous reset assertion immediately forces:
  - Mux_Output=0, Channel_Out=0, Sample_Valid=0, Sweep_Done=0.
  - ptr=0, dwell=0, state=IDLE.
  - This also applies to reset asserted mid-scan.
- Reset release is synchronised by the system; the first enabled edge after release behaves as described under Operation.
- Latency is 1 cycle: Data_In and Selector sampled at edge t appear on Mux_Output/Channel_Out after edge t.
- Sample_Valid and Sweep_Done are registered and aligned with the Mux_Output update they describe.
- Scan period: exactly N_CHANNELS*DWELL enabled cycles between consecutive Sweep_Done pulses.
- Mode and Selector take effect at the next edge; no extra pipeline stage.

## Test plan
Common setup unless a scenario says otherwise: N_BITS=8, N_CHANNELS=8, SEL_WIDTH=3, DWELL=4, channel k = 8'h10+k.
- Reset: hold reset=0 for 3 cycles with Enable=1, Mode=1 → all outputs 0 throughout, and no Sample_Valid pulse.
- Manual selection: Enable=1, Mode=0, Selector=5, then 2, each for 3 cycles.
  - After the first edge: Mux_Output=8'h15, Channel_Out=5, Sample_Valid=1 every cycle.
  - After the switch: Mux_Output=8'h12 one cycle later.
- Full scan: Mode=1 for 40 cycles.
  - Mux_Output steps 8'h10, 8'h11 … 8'h17, each held 4 cycles.
  - Sample_Valid pulses every 4th cycle.
  - Sweep_Done pulses once with Channel_Out=7.
  - Mux_Output=8'h10 again at cycle 33.
- Freeze/resume: in scan, drop Enable at channel 3, dwell=2, for 5 cycles.
  - While frozen: Mux_Output holds 8'h13 and there are no pulses.
  - After Enable returns: 2 more cycles on channel 3, then 8'h14 loads with Sample_Valid.
- Non-power-of-two: N_CHANNELS=5, SEL_WIDTH=3.
  - Manual, Selector=6 → outputs hold and Sample_Valid=0.
  - Scan → sequence 0,1,2,3,4,0, with Sweep_Done on channel 4.
- Async reset mid-scan: assert reset between clock edges while on channel 6 → outputs 0 before the next edge. After release with Mode=1, the scan restarts at 8'h10.

Source files
------------

// File: rtl/mux_scan_n_to_1.sv
// Registered N-to-1 multiplexer with manual channel selection and round-robin
// scanning; reports the presented channel and pulses sample/sweep markers.
module mux_scan_n_to_1 #(
    parameter int N_BITS     = 8,
    parameter int N_CHANNELS = 8,
    parameter int SEL_WIDTH  = 3,
    parameter int DWELL      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Enable,
    input  logic                         Mode,
    input  logic [SEL_WIDTH-1:0]         Selector,
    input  logic [N_CHANNELS*N_BITS-1:0] Data_In,
    output logic [N_BITS-1:0]            Mux_Output,
    output logic [SEL_WIDTH-1:0]         Channel_Out,
    output logic                         Sample_Valid,
    output logic                         Sweep_Done
);

    localparam int DW_WIDTH = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_WIDTH:0]   NUM_CH     = (SEL_WIDTH+1)'(N_CHANNELS);
    localparam logic [SEL_WIDTH-1:0] LAST_CH    = SEL_WIDTH'(N_CHANNELS - 1);
    localparam logic [DW_WIDTH-1:0]  LAST_DWELL = DW_WIDTH'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t                state_r;
    logic [SEL_WIDTH-1:0]  ptr_r;
    logic [DW_WIDTH-1:0]   dwell_r;
    logic [N_BITS-1:0]     chan_s [N_CHANNELS];
    logic                  sel_ok_s;
    logic [SEL_WIDTH-1:0]  scan_ptr_s;
    logic [DW_WIDTH-1:0]   scan_dwell_s;

    for (genvar k = 0; k < N_CHANNELS; k++) begin : g_unpack
        assign chan_s[k] = Data_In[k*N_BITS +: N_BITS];
    end

    assign sel_ok_s = ({1'b0, Selector} < NUM_CH);

    // Coming straight out of manual mode the scan position is forced to the
    // sweep start, so a corrupted ptr/dwell can never leak into a new sweep.
    always_comb begin
        scan_ptr_s   = ptr_r;
        scan_dwell_s = dwell_r;
        if (state_r == MANUAL) begin
            scan_ptr_s   = '0;
            scan_dwell_s = '0;
        end else begin
            scan_ptr_s   = ptr_r;
            scan_dwell_s = dwell_r;
        end
    end

    // Mode FSM together with all registered datapath outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            dwell_r      <= '0;
            Mux_Output   <= '0;
            Channel_Out  <= '0;
            Sample_Valid <= 1'b0;
            Sweep_Done   <= 1'b0;
        end else if (!Enable) begin
            state_r      <= IDLE;
            Sample_Valid <= 1'b0;
            Sweep_Done   <= 1'b0;
        end else if (!Mode) begin
            state_r    <= MANUAL;
            ptr_r      <= '0;
            dwell_r    <= '0;
            Sweep_Done <= 1'b0;
            if (sel_ok_s) begin
                Mux_Output   <= chan_s[Selector];
                Channel_Out  <= Selector;
                Sample_Valid <= 1'b1;
            end else begin
                Sample_Valid <= 1'b0;
            end
        end else begin
            state_r <= SCAN;
            if (scan_dwell_s == '0) begin
                Mux_Output   <= chan_s[scan_ptr_s];
                Channel_Out  <= scan_ptr_s;
                Sample_Valid <= 1'b1;
                Sweep_Done   <= (scan_ptr_s == LAST_CH);
            end else begin
                Sample_Valid <= 1'b0;
                Sweep_Done   <= 1'b0;
            end
            if (scan_dwell_s == LAST_DWELL) begin
                dwell_r <= '0;
                ptr_r   <= (scan_ptr_s == LAST_CH) ? '0 : scan_ptr_s + 1'b1;
            end else begin
                dwell_r <= scan_dwell_s + 1'b1;
                ptr_r   <= scan_ptr_s;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_n_to_1.sv
// Directed self-checking bench for mux_scan_n_to_1: an 8-channel instance and
// a 5-channel (non-power-of-two) instance share clock and control inputs.
module tb_mux_scan_n_to_1;

    logic        clk;
    logic        reset;
    logic        Enable;
    logic        Mode;
    logic [2:0]  Selector;
    logic [63:0] data8;
    logic [39:0] data5;
    logic [7:0]  mux8, mux5;
    logic [2:0]  ch8, ch5;
    logic        sv8, sv5, sd8, sd5;

    int n_checks = 0;
    int n_fail   = 0;

    mux_scan_n_to_1 #(.N_BITS(8), .N_CHANNELS(8), .SEL_WIDTH(3), .DWELL(4)) dut8 (
        .clk(clk), .reset(reset), .Enable(Enable), .Mode(Mode),
        .Selector(Selector), .Data_In(data8), .Mux_Output(mux8),
        .Channel_Out(ch8), .Sample_Valid(sv8), .Sweep_Done(sd8)
    );

    mux_scan_n_to_1 #(.N_BITS(8), .N_CHANNELS(5), .SEL_WIDTH(3), .DWELL(4)) dut5 (
        .clk(clk), .reset(reset), .Enable(Enable), .Mode(Mode),
        .Selector(Selector), .Data_In(data5), .Mux_Output(mux5),
        .Channel_Out(ch5), .Sample_Valid(sv5), .Sweep_Done(sd5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data();
        for (int k = 0; k < 8; k++) data8[k*8 +: 8] = 8'(8'h10 + k);
        for (int k = 0; k < 5; k++) data5[k*8 +: 8] = 8'(8'h10 + k);
    endtask

    task automatic test_reset();
        reset = 1'b0; Enable = 1'b1; Mode = 1'b1; Selector = 3'd0;
        load_data();
        #2;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({mux8, ch8, sv8, sd8} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got mux=%h ch=%0d sv=%b sd=%b, want all 0",
                         i, mux8, ch8, sv8, sd8);
            end
        end
        Mode = 1'b0; Selector = 3'd5;
        reset = 1'b1;
    endtask

    task automatic test_manual();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (mux8 !== 8'h15 || ch8 !== 3'd5 || sv8 !== 1'b1 || sd8 !== 1'b0) begin
                n_fail++;
                $display("FAIL manual_sel5 cycle %0d: got mux=%h ch=%0d sv=%b sd=%b, want 15/5/1/0",
                         i, mux8, ch8, sv8, sd8);
            end
        end
        Selector = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (mux8 !== 8'h12 || ch8 !== 3'd2 || sv8 !== 1'b1 || sd8 !== 1'b0) begin
                n_fail++;
                $display("FAIL manual_sel2 cycle %0d: got mux=%h ch=%0d sv=%b sd=%b, want 12/2/1/0",
                         i, mux8, ch8, sv8, sd8);
            end
        end
    endtask

    task automatic test_full_scan();
        int sweeps = 0;
        logic [2:0] ech;
        logic       esv;
        Mode = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            ech = 3'(((c - 1) / 4) % 8);
            esv = ((c - 1) % 4 == 0);
            if (sd8) sweeps++;
            n_checks++;
            if (mux8 !== 8'(8'h10 + ech) || ch8 !== ech || sv8 !== esv ||
                sd8 !== (esv && ech == 3'd7)) begin
                n_fail++;
                $display("FAIL full_scan cycle %0d: got mux=%h ch=%0d sv=%b sd=%b, want %h/%0d/%b/%b",
                         c, mux8, ch8, sv8, sd8, 8'(8'h10 + ech), ech, esv, esv && ech == 3'd7);
            end
        end
        n_checks++;
        if (sweeps !== 1) begin
            n_fail++;
            $display("FAIL sweep_count: got %0d pulses, want 1", sweeps);
        end
    endtask

    task automatic test_freeze_resume();
        Mode = 1'b0; Selector = 3'd2;
        tick();
        Mode = 1'b1;
        repeat (14) tick();
        Enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (mux8 !== 8'h13 || ch8 !== 3'd3 || sv8 !== 1'b0 || sd8 !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze cycle %0d: got mux=%h ch=%0d sv=%b sd=%b, want 13/3/0/0",
                         i, mux8, ch8, sv8, sd8);
            end
        end
        Enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (mux8 !== 8'h13 || sv8 !== 1'b0) begin
                n_fail++;
                $display("FAIL resume_dwell cycle %0d: got mux=%h sv=%b, want 13/0", i, mux8, sv8);
            end
        end
        tick();
        n_checks++;
        if (mux8 !== 8'h14 || ch8 !== 3'd4 || sv8 !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_load: got mux=%h ch=%0d sv=%b, want 14/4/1", mux8, ch8, sv8);
        end
    endtask

    task automatic test_async_reset();
        Mode = 1'b0;
        tick();
        Mode = 1'b1;
        repeat (25) tick();
        n_checks++;
        if (mux8 !== 8'h16 || ch8 !== 3'd6) begin
            n_fail++;
            $display("FAIL pre_reset_ch6: got mux=%h ch=%0d, want 16/6", mux8, ch8);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({mux8, ch8, sv8, sd8} !== 13'd0) begin
            n_fail++;
            $display("FAIL async_reset: got mux=%h ch=%0d sv=%b sd=%b, want all 0",
                     mux8, ch8, sv8, sd8);
        end
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (mux8 !== 8'h10 || ch8 !== 3'd0 || sv8 !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_scan: got mux=%h ch=%0d sv=%b, want 10/0/1", mux8, ch8, sv8);
        end
        data8[7:0] = 8'hAA;
        tick();
        n_checks++;
        if (mux8 !== 8'h10 || sv8 !== 1'b0) begin
            n_fail++;
            $display("FAIL data_change_in_dwell: got mux=%h sv=%b, want 10/0", mux8, sv8);
        end
        load_data();
    endtask

    task automatic test_non_pow2();
        logic [2:0] ech;
        logic       esv;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        Mode = 1'b0; Selector = 3'd1;
        tick();
        n_checks++;
        if (mux5 !== 8'h11 || ch5 !== 3'd1 || sv5 !== 1'b1) begin
            n_fail++;
            $display("FAIL np2_manual_sel1: got mux=%h ch=%0d sv=%b, want 11/1/1", mux5, ch5, sv5);
        end
        Selector = 3'd6;
        tick();
        n_checks++;
        if (mux5 !== 8'h11 || ch5 !== 3'd1 || sv5 !== 1'b0 || sd5 !== 1'b0) begin
            n_fail++;
            $display("FAIL np2_out_of_range: got mux=%h ch=%0d sv=%b sd=%b, want 11/1/0/0",
                     mux5, ch5, sv5, sd5);
        end
        Mode = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            ech = 3'(((c - 1) / 4) % 5);
            esv = ((c - 1) % 4 == 0);
            n_checks++;
            if (mux5 !== 8'(8'h10 + ech) || ch5 !== ech || sv5 !== esv ||
                sd5 !== (esv && ech == 3'd4)) begin
                n_fail++;
                $display("FAIL np2_scan cycle %0d: got mux=%h ch=%0d sv=%b sd=%b, want %h/%0d/%b/%b",
                         c, mux5, ch5, sv5, sd5, 8'(8'h10 + ech), ech, esv, esv && ech == 3'd4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_full_scan();
        test_freeze_resume();
        test_async_reset();
        test_non_pow2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
